// File: rtl/v_issue_queue.sv
// In-order vector instruction issue queue: DEPTH-entry FIFO of instr/rs1/rs2.
// Only one non-vconfig instruction may be outstanding; vconfig issues back-to-back.
module v_issue_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      in_valid,
   input  logic [31:0]               in_instr,
   input  logic [XLEN-1:0]           in_rs1,
   input  logic [XLEN-1:0]           in_rs2,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [31:0]               out_instr,
   output logic [XLEN-1:0]           out_rs1,
   output logic [XLEN-1:0]           out_rs2,
   input  logic                      issue_ack,
   input  logic                      v_done,
   input  logic                      flush,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      v_busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [0:0]  READY = 1'b0;
   localparam logic [0:0]  BUSY  = 1'b1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [31:0]     mem_instr [DEPTH];
   logic [XLEN-1:0] mem_rs1   [DEPTH];
   logic [XLEN-1:0] mem_rs2   [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [0:0]    state;
   logic          empty;
   logic          push;
   logic          pop;
   logic          head_vcfg;

   assign empty     = (count == '0);
   assign in_ready  = (count < CNT_FULL);
   assign out_valid = (state == READY) && !empty;
   assign v_busy    = !empty || (state == BUSY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && issue_ack;
   assign head_vcfg = (out_instr[6:0] == 7'b1010111) && (out_instr[14:12] == 3'b111);

   // Head fields read as zero while empty so stale storage never leaks out.
   always_comb begin
      out_instr = '0;
      out_rs1   = '0;
      out_rs2   = '0;
      if (!empty) begin
         out_instr = mem_instr[rd_ptr];
         out_rs1   = mem_rs1[rd_ptr];
         out_rs2   = mem_rs2[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_instr[wr_ptr] <= in_instr;
         mem_rs1[wr_ptr]   <= in_rs1;
         mem_rs2[wr_ptr]   <= in_rs2;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         state  <= READY;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         state  <= READY;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         if (state == READY) begin
            if (pop && !head_vcfg) state <= BUSY;
         end else if (v_done) begin
            state <= READY;
         end
      end
   end

endmodule

// File: tb/tb_v_issue_queue.sv
// Scoreboard bench for v_issue_queue: stimulus queues expected entries,
// a negedge monitor pops and compares every issued head.
module tb_v_issue_queue;

   localparam logic [31:0] VADD  = 32'h02208057;
   localparam logic [31:0] VADD2 = 32'h02310057;
   localparam logic [31:0] VADD3 = 32'h02418057;
   localparam logic [31:0] VSET  = 32'h0D007057;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } ent_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_rs1 = '0;
   logic [31:0] in_rs2 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_rs1;
   logic [31:0] out_rs2;
   logic        issue_ack = 1'b0;
   logic        v_done = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  count;
   logic        v_busy;

   int   total = 0;
   int   bad = 0;
   ent_t exp_q[$];

   v_issue_queue #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .issue_ack(issue_ack), .v_done(v_done), .flush(flush),
      .count(count), .v_busy(v_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ack, input logic done, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_rs1    = r1;
      in_rs2    = r2;
      issue_ack = ack;
      v_done    = done;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_push(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      ent_t e;
      e.instr = ins;
      e.rs1   = r1;
      e.rs2   = r2;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      ent_t e;
      if (nrst && out_valid && issue_ack) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pop_instr", out_instr, e.instr);
            chk("pop_rs1", out_rs1, e.rs1);
            chk("pop_rs2", out_rs2, e.rs2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      #1 nrst = 1'b0;
      #11;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_v_busy", 32'(v_busy), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      nrst = 1'b1;

      // single push, issue, complete
      expect_push(VADD, 32'd5, 32'd7);
      drive(1, VADD, 32'd5, 32'd7, 0, 0, 0);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_instr", out_instr, VADD);
      chk("t1_out_rs1", out_rs1, 32'd5);
      chk("t1_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t1_busy_out_valid", 32'(out_valid), 32'd0);
      chk("t1_busy_v_busy", 32'(v_busy), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t1_done_v_busy", 32'(v_busy), 32'd0);

      // fill to full, fifth push dropped, drain in order
      for (int i = 0; i < 5; i++) begin
         ins = VADD | (32'(i) << 20);
         if (i < 4) expect_push(ins, 32'h10 + 32'(i), 32'h20 + 32'(i));
         drive(1, ins, 32'h10 + 32'(i), 32'h20 + 32'(i), 0, 0, 0);
         if (i == 3) begin
            chk("t2_full_in_ready", 32'(in_ready), 32'd0);
            chk("t2_full_count", 32'(count), 32'd4);
         end
      end
      chk("t2_after5_count", 32'(count), 32'd4);
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         chk("t2_busy_out_valid", 32'(out_valid), 32'd0);
         drive(0, 0, 0, 0, 0, 1, 0);
         chk("t2_drain_count", 32'(count), 32'(3 - k));
      end

      // vconfig issues back-to-back
      expect_push(VSET, 32'd16, 32'hC0);
      drive(1, VSET, 32'd16, 32'hC0, 0, 0, 0);
      expect_push(VADD, 32'd1, 32'd2);
      drive(1, VADD, 32'd1, 32'd2, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t3_vcfg_out_valid", 32'(out_valid), 32'd1);
      chk("t3_vcfg_next_instr", out_instr, VADD);
      chk("t3_vcfg_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t3_vadd_out_valid", 32'(out_valid), 32'd0);
      chk("t3_vadd_v_busy", 32'(v_busy), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t3_done_v_busy", 32'(v_busy), 32'd0);

      // simultaneous push and pop with vconfig head
      expect_push(VSET, 32'd3, 32'd4);
      drive(1, VSET, 32'd3, 32'd4, 0, 0, 0);
      expect_push(VADD2, 32'd6, 32'd7);
      drive(1, VADD2, 32'd6, 32'd7, 0, 0, 0);
      chk("t4_count2", 32'(count), 32'd2);
      expect_push(VADD3, 32'd8, 32'd9);
      drive(1, VADD3, 32'd8, 32'd9, 1, 0, 0);
      chk("t4_pushpop_count", 32'(count), 32'd2);
      chk("t4_pushpop_head", out_instr, VADD2);
      chk("t4_pushpop_valid", 32'(out_valid), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t4_busy_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t4_drained_count", 32'(count), 32'd0);

      // pointer wrap with streaming vconfig
      for (int i = 0; i < 6; i++) begin
         expect_push(VSET, 32'h40 + 32'(i), 32'h100 + 32'(i));
         drive(1, VSET, 32'h40 + 32'(i), 32'h100 + 32'(i), 1, 0, 0);
      end
      chk("t4_wrap_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t4_wrap_drained", 32'(count), 32'd0);

      // flush while busy with a coincident push
      expect_push(VADD, 32'hA, 32'hB);
      drive(1, VADD, 32'hA, 32'hB, 0, 0, 0);
      expect_push(VADD2, 32'h11, 32'h21);
      drive(1, VADD2, 32'h11, 32'h21, 1, 0, 0);
      expect_push(VADD3, 32'h12, 32'h22);
      drive(1, VADD3, 32'h12, 32'h22, 0, 0, 0);
      expect_push(VADD | (32'd1 << 20), 32'h13, 32'h23);
      drive(1, VADD | (32'd1 << 20), 32'h13, 32'h23, 0, 0, 0);
      chk("t5_pre_count", 32'(count), 32'd3);
      chk("t5_pre_out_valid", 32'(out_valid), 32'd0);
      drive(1, 32'hDEAD8057, 32'h55, 32'h66, 0, 0, 1);
      exp_q.delete();
      chk("t5_flush_count", 32'(count), 32'd0);
      chk("t5_flush_out_valid", 32'(out_valid), 32'd0);
      chk("t5_flush_v_busy", 32'(v_busy), 32'd0);
      chk("t5_flush_in_ready", 32'(in_ready), 32'd1);
      chk("t5_flush_out_instr", out_instr, 32'd0);
      expect_push(VADD2, 32'h77, 32'h88);
      drive(1, VADD2, 32'h77, 32'h88, 0, 0, 0);
      chk("t5_after_head", out_instr, VADD2);
      drive(0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t5_after_count", 32'(count), 32'd0);

      // asynchronous reset while busy
      expect_push(VADD, 32'h31, 32'h41);
      drive(1, VADD, 32'h31, 32'h41, 0, 0, 0);
      expect_push(VADD2, 32'h32, 32'h42);
      drive(1, VADD2, 32'h32, 32'h42, 0, 0, 0);
      expect_push(VADD3, 32'h33, 32'h43);
      drive(1, VADD3, 32'h33, 32'h43, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
      issue_ack = 1'b0;
      chk("t6_pre_count", 32'(count), 32'd2);
      chk("t6_pre_v_busy", 32'(v_busy), 32'd1);
      #2 nrst = 1'b0;
      #1;
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_v_busy", 32'(v_busy), 32'd0);
      chk("t6_async_out_valid", 32'(out_valid), 32'd0);
      chk("t6_async_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      #3 nrst = 1'b1;
      expect_push(VSET, 32'h9, 32'h9);
      drive(1, VSET, 32'h9, 32'h9, 0, 0, 0);
      chk("t6_post_out_valid", 32'(out_valid), 32'd1);
      chk("t6_post_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("t6_end_count", 32'(count), 32'd0);
      chk("t6_end_v_busy", 32'(v_busy), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/v_issue_queue.md
Name: v_issue_queue

Overview:
- In-order instruction buffer between the scalar core's vector dispatch and the vector decoder.
- Accepts 32-bit vector instructions together with their scalar operands (rs1/rs2 values) and holds them in a DEPTH-entry FIFO.
- Presents the head entry to the decoder and allows only one non-vconfig vector instruction outstanding at a time; the next entry issues only after the execution units signal completion.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, at least 2
XLEN, 32, width of the scalar operand fields

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
in_valid  input  1  scalar core presents an instruction
in_instr  input  32  vector instruction word
in_rs1  input  XLEN  scalar rs1 value (AVL, base address, scalar operand)
in_rs2  input  XLEN  scalar rs2 value (stride, vtype source)
in_ready  output  1  queue can accept an entry
out_valid  output  1  head entry is available for issue
out_instr  output  32  head instruction, to decoder instr
out_rs1  output  XLEN  head rs1 value
out_rs2  output  XLEN  head rs2 value
issue_ack  input  1  decoder/execute takes the head this cycle
v_done  input  1  outstanding vector instruction completed (1-cycle pulse)
flush  input  1  synchronous clear of the queue and FSM
count  output  $clog2(DEPTH)+1  number of valid entries
v_busy  output  1  queue non-empty or an instruction outstanding

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low on nrst.
- Reset values: count=0, wr_ptr=rd_ptr=0, state=READY. Storage contents are don't-care.
  - Resulting outputs: in_ready=1, out_valid=0, v_busy=0.
  - out_instr/out_rs1/out_rs2 read 0 whenever the queue is empty.
- Push occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH); it is combinational from count and does not look at issue_ack.
  - in_valid while full is ignored; the entry is not written.
- Pop occurs when out_valid && issue_ack. issue_ack while out_valid=0 is ignored.
- out_valid = (state==READY) && (count!=0). Head fields are driven combinationally from storage[rd_ptr].
- Latency: an entry pushed into an empty queue at edge N is visible with out_valid=1 immediately after edge N.
- Push and pop in the same cycle: both take effect and count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: READY and BUSY.
  - READY, on pop:
    - if the popped instr is vconfig (instr[6:0]=7'b1010111 and instr[14:12]=3'b111), stay in READY, so back-to-back issue is allowed;
    - any other popped instr moves the FSM to BUSY.
  - BUSY: out_valid=0. On v_done go to READY; the next head may issue in the cycle after v_done.
  - v_done while in READY is ignored.
- flush: next edge sets count=0, pointers=0, state=READY.
  - flush has priority over push, pop and v_done in the same cycle.
  - A push coincident with flush is dropped.
- v_busy = (count!=0) || (state==BUSY).
- Reset mid-operation (nrst low in any state): all state returns to reset values immediately, asynchronously. An outstanding BUSY is abandoned.

Test Plan:
- Reset then single push of vadd.vv (32'h02208057), rs1=5: out_valid=1 with out_instr=32'h02208057 and count=1 on the next cycle. Pulse issue_ack: out_valid=0, v_busy=1, state=BUSY. Pulse v_done: v_busy=0.
- Fill: push 5 instructions back-to-back with DEPTH=4, no ack. Required: in_ready=0 after the 4th push, count=4, the 5th is dropped. Then ack and v_done four times: outputs appear in push order.
- Vconfig chain: push vsetvli (32'h0D007057) then vadd. Ack vsetvli: state stays READY and vadd shows out_valid=1 in the next cycle without v_done. Ack vadd: BUSY.
- Simultaneous push/pop at count=2 in READY with a vconfig head: count stays 2. Pointer wrap: after 6 pushes/pops, order is preserved and out_rs2 matches the pushed value.
- flush while BUSY with count=3 and a simultaneous in_valid: next cycle count=0, out_valid=0, v_busy=0, in_ready=1, and the pushed entry is absent.
- Async reset: drop nrst mid-cycle while BUSY with count=2. Required without waiting for a clock edge: count=0, v_busy=0, out_valid=0. After release, the queue operates from empty.
